// File: rtl/seq_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) with a HI/LO result pair.
module seq_alu #(
  parameter int DATA_SIZE = 32,
  parameter int FUNC_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] alu_a,
  input  logic [DATA_SIZE-1:0] alu_b,
  input  logic [FUNC_SIZE-1:0] i_func,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_lo,
  output logic [DATA_SIZE-1:0] out_hi
);

  localparam int SHW = $clog2(DATA_SIZE);
  localparam int CW  = $clog2(DATA_SIZE + 1);

  localparam logic [FUNC_SIZE-1:0] F_ADD  = FUNC_SIZE'(1);
  localparam logic [FUNC_SIZE-1:0] F_SUB  = FUNC_SIZE'(2);
  localparam logic [FUNC_SIZE-1:0] F_AND  = FUNC_SIZE'(3);
  localparam logic [FUNC_SIZE-1:0] F_OR   = FUNC_SIZE'(4);
  localparam logic [FUNC_SIZE-1:0] F_XOR  = FUNC_SIZE'(5);
  localparam logic [FUNC_SIZE-1:0] F_SLT  = FUNC_SIZE'(6);
  localparam logic [FUNC_SIZE-1:0] F_SLTU = FUNC_SIZE'(7);
  localparam logic [FUNC_SIZE-1:0] F_SLL  = FUNC_SIZE'(8);
  localparam logic [FUNC_SIZE-1:0] F_SRL  = FUNC_SIZE'(9);
  localparam logic [FUNC_SIZE-1:0] F_SRA  = FUNC_SIZE'(10);
  localparam logic [FUNC_SIZE-1:0] F_MULT = FUNC_SIZE'(11);
  localparam logic [FUNC_SIZE-1:0] F_DIVU = FUNC_SIZE'(12);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_inc;
  logic                   last_step;
  logic                   accept;
  logic                   div_zero;
  logic [DATA_SIZE-1:0]   hi_acc, lo_acc, opnd;

  logic signed [DATA_SIZE-1:0] a_s, b_s;
  logic [SHW-1:0]              shamt;
  logic [DATA_SIZE-1:0]        alu_lo_p0, alu_hi_p0;

  logic [DATA_SIZE:0]     mul_sum;
  logic [DATA_SIZE-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [DATA_SIZE:0]     div_shift, div_diff;
  logic                   div_ge;
  logic [DATA_SIZE-1:0]   div_rem_nxt, div_quo_nxt;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign div_zero  = (alu_b == '0);
  assign cnt_inc   = cnt + 1'b1;
  assign last_step = (cnt_inc == CW'(DATA_SIZE));

  assign a_s   = alu_a;
  assign b_s   = alu_b;
  assign shamt = alu_b[SHW-1:0];

  // Stage p0: single-cycle result, registered into out_lo/out_hi on accept
  always_comb begin
    alu_lo_p0 = '0;
    alu_hi_p0 = '0;
    case (i_func)
      F_ADD:  alu_lo_p0 = alu_a + alu_b;
      F_SUB:  alu_lo_p0 = alu_a - alu_b;
      F_AND:  alu_lo_p0 = alu_a & alu_b;
      F_OR:   alu_lo_p0 = alu_a | alu_b;
      F_XOR:  alu_lo_p0 = alu_a ^ alu_b;
      F_SLT:  alu_lo_p0 = {{(DATA_SIZE-1){1'b0}}, (a_s < b_s)};
      F_SLTU: alu_lo_p0 = {{(DATA_SIZE-1){1'b0}}, (alu_a < alu_b)};
      F_SLL:  alu_lo_p0 = alu_a << shamt;
      F_SRL:  alu_lo_p0 = alu_a >> shamt;
      F_SRA:  alu_lo_p0 = a_s >>> shamt;
      F_DIVU: begin
        alu_lo_p0 = '1;
        alu_hi_p0 = alu_a;
      end
      default: ;
    endcase
  end

  // Shift-add step: hi_acc accumulates, lo_acc holds the remaining multiplier bits
  assign mul_sum    = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nxt = mul_sum[DATA_SIZE:1];
  assign mul_lo_nxt = {mul_sum[0], lo_acc[DATA_SIZE-1:1]};

  // Restoring step: partial remainder is always below the divisor, so the
  // borrow out of the (DATA_SIZE+1)-bit subtraction decides the quotient bit
  assign div_shift   = {hi_acc, lo_acc[DATA_SIZE-1]};
  assign div_diff    = div_shift - {1'b0, opnd};
  assign div_ge      = ~div_diff[DATA_SIZE];
  assign div_rem_nxt = div_ge ? div_diff[DATA_SIZE-1:0] : div_shift[DATA_SIZE-1:0];
  assign div_quo_nxt = {lo_acc[DATA_SIZE-2:0], div_ge};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && i_func == F_MULT)                 state_nxt = MUL;
        else if (accept && i_func == F_DIVU && !div_zero) state_nxt = DIV;
      end
      MUL, DIV: if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p1: registered results and iterative engine state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hi_acc    <= '0;
      lo_acc    <= '0;
      opnd      <= '0;
      out_valid <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            if (i_func == F_MULT) begin
              hi_acc <= '0;
              lo_acc <= alu_b;
              opnd   <= alu_a;
            end else if (i_func == F_DIVU && !div_zero) begin
              hi_acc <= '0;
              lo_acc <= alu_a;
              opnd   <= alu_b;
            end else begin
              out_valid <= 1'b1;
              out_lo    <= alu_lo_p0;
              out_hi    <= alu_hi_p0;
            end
          end
        end
        MUL: begin
          cnt    <= last_step ? '0 : cnt_inc;
          hi_acc <= mul_hi_nxt;
          lo_acc <= mul_lo_nxt;
          if (last_step) begin
            out_valid <= 1'b1;
            out_lo    <= mul_lo_nxt;
            out_hi    <= mul_hi_nxt;
          end
        end
        DIV: begin
          cnt    <= last_step ? '0 : cnt_inc;
          hi_acc <= div_rem_nxt;
          lo_acc <= div_quo_nxt;
          if (last_step) begin
            out_valid <= 1'b1;
            out_lo    <= div_quo_nxt;
            out_hi    <= div_rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and randomized traffic against a cycle-level
// behavioural model, plus an 8-bit instance for the narrow multiply case.
module tb_seq_alu;
  localparam int DS = 32;
  localparam int FS = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid;
  logic [DS-1:0] alu_a, alu_b, out_lo, out_hi;
  logic [FS-1:0] i_func;

  seq_alu #(.DATA_SIZE(DS), .FUNC_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .i_func(i_func),
    .out_valid(out_valid), .out_lo(out_lo), .out_hi(out_hi)
  );

  logic          rst8, iv8, rdy8, ov8;
  logic [7:0]    a8, b8, lo8, hi8;
  logic [FS-1:0] f8;

  seq_alu #(.DATA_SIZE(8), .FUNC_SIZE(FS)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(rdy8),
    .alu_a(a8), .alu_b(b8), .i_func(f8),
    .out_valid(ov8), .out_lo(lo8), .out_hi(hi8)
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must show after the next edge
  bit            exp_valid, exp_ready;
  logic [DS-1:0] exp_lo, exp_hi, pend_lo, pend_hi;
  int            busy_left;
  logic [DS-1:0] got_lo[$], got_hi[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_op(input int w, input int f,
                                 input longint unsigned ain, input longint unsigned bin,
                                 output longint unsigned lo, output longint unsigned hi,
                                 output bit multi);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned sb   = 64'd1 << (w - 1);
    longint unsigned a    = ain & mask;
    longint unsigned b    = bin & mask;
    int              sh   = int'(b % longint'(w));
    lo = 0; hi = 0; multi = 0;
    case (f)
      1:  lo = (a + b) & mask;
      2:  lo = (a - b) & mask;
      3:  lo = a & b;
      4:  lo = a | b;
      5:  lo = a ^ b;
      6:  lo = ((a ^ sb) < (b ^ sb)) ? 1 : 0;
      7:  lo = (a < b) ? 1 : 0;
      8:  lo = (a << sh) & mask;
      9:  lo = a >> sh;
      10: begin
        lo = a >> sh;
        if ((a & sb) != 0) lo = lo | (mask & ~(mask >> sh));
      end
      11: begin
        lo = (a * b) & mask;
        hi = (a * b) >> w;
        multi = 1;
      end
      12: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
          multi = 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit iv, input int f,
                            input logic [DS-1:0] a, input logic [DS-1:0] b, output bit acc);
    longint unsigned lo, hi;
    bit multi;
    acc = 0;
    exp_valid = 0;
    if (r) begin
      exp_ready = 1; exp_lo = '0; exp_hi = '0; busy_left = 0;
      return;
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        exp_valid = 1; exp_ready = 1; exp_lo = pend_lo; exp_hi = pend_hi;
      end
      return;
    end
    if (iv) begin
      acc = 1;
      ref_op(DS, f, longint'(a), longint'(b), lo, hi, multi);
      if (multi) begin
        busy_left = DS; exp_ready = 0;
        pend_lo = lo[DS-1:0]; pend_hi = hi[DS-1:0];
      end else begin
        exp_valid = 1; exp_lo = lo[DS-1:0]; exp_hi = hi[DS-1:0];
      end
    end
  endtask

  task automatic tick(input bit r, input bit iv, input int f,
                      input logic [DS-1:0] a, input logic [DS-1:0] b, output bit acc);
    rst = r; in_valid = iv; i_func = FS'(f); alu_a = a; alu_b = b;
    model_step(r, iv, f, a, b, acc);
    @(posedge clk);
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    check("out_lo", {32'd0, out_lo}, {32'd0, exp_lo});
    check("out_hi", {32'd0, out_hi}, {32'd0, exp_hi});
    if (out_valid === 1'b1) begin
      got_lo.push_back(out_lo);
      got_hi.push_back(out_hi);
    end
  endtask

  task automatic issue(input int f, input logic [DS-1:0] a, input logic [DS-1:0] b);
    bit acc;
    int n = 0;
    do begin
      tick(0, 1, f, a, b, acc);
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_accept: got not-accepted required accepted after %0d cycles", n);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(0, 0, 0, '0, '0, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish required finish by 500000");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n;
    longint unsigned rlo, rhi;
    bit rmul;
    logic [DS-1:0] lit_lo[12];
    logic [DS-1:0] lit_hi[12];

    rst = 1; in_valid = 1; i_func = '0; alu_a = '0; alu_b = '0;
    rst8 = 1; iv8 = 0; f8 = '0; a8 = '0; b8 = '0;
    exp_valid = 0; exp_ready = 1; exp_lo = '0; exp_hi = '0; busy_left = 0;
    pend_lo = '0; pend_hi = '0;

    // Model pinned against hand-computed values
    ref_op(32, 10, 64'h80000000, 64'd4, rlo, rhi, rmul);
    check("ref_sra", rlo, 64'hF8000000);
    ref_op(32, 6, 64'hFFFFFFFF, 64'd1, rlo, rhi, rmul);
    check("ref_slt", rlo, 64'd1);
    ref_op(8, 11, 64'hFF, 64'hFF, rlo, rhi, rmul);
    check("ref_mul8", {rhi[31:0], rlo[31:0]}, {32'hFE, 32'h01});

    @(negedge clk);
    tick(1, 1, 1, 32'd5, 32'd3, acc);
    tick(1, 1, 1, 32'd5, 32'd3, acc);

    issue(1, 32'd5, 32'd3);
    issue(2, 32'd3, 32'd5);
    issue(6, 32'hFFFFFFFF, 32'd1);
    issue(7, 32'hFFFFFFFF, 32'd1);
    issue(10, 32'h80000000, 32'd4);
    issue(11, 32'hFFFFFFFF, 32'd2);
    issue(1, 32'd1, 32'd1);
    issue(12, 32'd100, 32'd7);
    issue(12, 32'd9, 32'd0);
    issue(12, 32'd1000, 32'd3);
    idle(9);
    tick(1, 1, 5, 32'hF0, 32'hFF, acc);
    issue(5, 32'hF0, 32'hFF);
    issue(0, 32'h1234, 32'h5678);
    issue(13, 32'h1234, 32'h5678);
    idle(2);

    lit_lo = '{32'd8, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'hFFFFFFFE,
               32'd2, 32'd14, 32'hFFFFFFFF, 32'h0F, 32'd0, 32'd0};
    lit_hi = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1,
               32'd0, 32'd2, 32'd9, 32'd0, 32'd0, 32'd0};
    check("result_count", 64'(got_lo.size()), 64'd12);
    for (int i = 0; i < 12 && i < got_lo.size(); i++) begin
      check($sformatf("lit_lo[%0d]", i), {32'd0, got_lo[i]}, {32'd0, lit_lo[i]});
      check($sformatf("lit_hi[%0d]", i), {32'd0, got_hi[i]}, {32'd0, lit_hi[i]});
    end

    // Multiply latency counted from the accepting edge
    issue(11, 32'd3, 32'd5);
    n = 0;
    do begin
      tick(0, 0, 0, '0, '0, acc);
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    check("mul_latency", 64'(n), 64'd32);
    check("mul_small_lo", {32'd0, out_lo}, 64'd15);

    // Randomized traffic with operand changes during stalls and rare resets
    for (int i = 0; i < 1500; i++) begin
      bit r, iv;
      int f;
      logic [DS-1:0] a, b;
      r  = ($urandom_range(0, 99) == 0);
      iv = ($urandom_range(0, 3) != 0);
      f  = int'($urandom_range(0, 14));
      a  = ($urandom_range(0, 3) == 0) ? DS'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = DS'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      tick(r, iv, f, a, b, acc);
    end
    idle(40);

    // 8-bit instance: reset then 0xFF * 0xFF
    rst8 = 1; iv8 = 1; f8 = FS'(11); a8 = 8'hFF; b8 = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("r8_ready", {63'd0, rdy8}, 64'd1);
    check("r8_valid", {63'd0, ov8}, 64'd0);
    check("r8_out", {48'd0, hi8, lo8}, 64'd0);
    rst8 = 0;
    @(posedge clk);
    @(negedge clk);
    iv8 = 0; a8 = 8'h00; b8 = 8'h00;
    check("m8_busy", {63'd0, rdy8}, 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (ov8 !== 1'b1 && n < 20);
    check("m8_latency", 64'(n), 64'd8);
    check("m8_hi", {56'd0, hi8}, 64'hFE);
    check("m8_lo", {56'd0, lo8}, 64'h01);
    check("m8_ready", {63'd0, rdy8}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
